// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core: DEPTH x DW word array,
// zero-cleared by a sweep after every reset. Optional access counters: DMEM_STATS_EN.
//
// state | meaning
// CLEAR | sweeping mem[0..DEPTH-1] to zero, accesses ignored
// IDLE  | ready, one access per cycle until rst
module data_mem_responder #(
  parameter int DEPTH = 128,
  parameter int DW    = 32,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  input  logic          OEN,
  output logic [DW-1:0] ReadDataMem,
  output logic          ready,
  output logic          err,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt
);

  typedef enum logic {CLEAR, IDLE} state_t;

  // One extra bit so DEPTH == 2**AW is representable and nothing is out of range.
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] mem [DEPTH];

  logic          clr_done, in_range, acc, wr_acc, rd_acc, oor;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_done) state_nxt = IDLE;
  end

  always_comb begin
    clr_done  = (clr_ptr == CLR_LAST);
    in_range  = ({1'b0, A} < DEPTH_L);
    acc       = (state == IDLE) && !CEN;
    wr_acc    = acc && !WEN && in_range;
    rd_acc    = acc && WEN && in_range;
    oor       = acc && !in_range;
    mem_we    = (state == CLEAR) || wr_acc;
    mem_addr  = (state == CLEAR) ? clr_ptr : A;
    mem_wdata = (state == CLEAR) ? '0 : Data2Mem;
  end

  assign ReadDataMem = OEN ? '0 : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
      rd_q    <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_done) ready <= 1'b1;
      end
      err <= oor;
      if (rd_acc)           rd_q <= mem[A];
      else if (oor && WEN)  rd_q <= '0;
    end
  end

  // Array has no reset of its own; the CLEAR sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 1'b1;
      if (wr_acc && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 1'b1;
    end
  end
`else
  assign rd_cnt = 16'h0;
  assign wr_cnt = 16'h0;
`endif

endmodule
